// File: rtl/alu_result_writeback_pkg.sv
// ============================================================================
// alu_result_writeback_pkg
// Opcodes, write-back targets, FSM states and opcode classification shared
// by the ALU result write-back block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_result_writeback_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    localparam logic [1:0] WB_TGT_GPR = 2'b00;
    localparam logic [1:0] WB_TGT_LO  = 2'b01;
    localparam logic [1:0] WB_TGT_HI  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LO_GPR = 3'd1,
        S_LO     = 3'd2,
        S_HI     = 3'd3,
        S_DROP   = 3'd4
    } wb_state_e;

    typedef enum logic [1:0] {
        CLS_ONE  = 2'd0,
        CLS_TWO  = 2'd1,
        CLS_DROP = 2'd2
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] op);
        case (op)
            OP_MUL, OP_DIV:                          return CLS_TWO;
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR,
            OP_NOR, OP_SLT, OP_SLL, OP_NEG, OP_NOT:  return CLS_ONE;
            default:                                 return CLS_DROP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wb_fifo.sv
// ============================================================================
// alu_wb_fifo
// Synchronous FIFO of {op, dest, result} entries; DEPTH must be a power of 2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_wb_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_result_writeback.sv
// ============================================================================
// alu_result_writeback
// Buffers ALU results and sequences them onto the 32-bit write-back bus.
// Optional zero/negative flags enabled by defining ALU_WB_FLAGS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_result_writeback
    import alu_result_writeback_pkg::*;
#(
    parameter int REG_SIZE   = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [2*REG_SIZE-1:0] in_result,
    input  logic [3:0]            in_dest,
    output logic                  wb_en,
    input  logic                  wb_ready,
    output logic [1:0]            wb_target,
    output logic [3:0]            wb_addr,
    output logic [REG_SIZE-1:0]   wb_data
`ifdef ALU_WB_FLAGS_EN
    ,
    output logic                  flag_z,
    output logic                  flag_n
`endif
);

    localparam int ENTRY_W = 8 + 2*REG_SIZE;

    logic [ENTRY_W-1:0]    head;
    logic [3:0]            head_op;
    logic [3:0]            head_dest;
    logic [2*REG_SIZE-1:0] head_res;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  beat_done;

    wb_state_e             state_q;
    logic                  wb_en_q;
    logic [1:0]            wb_target_q;
    logic [3:0]            wb_addr_q;
    logic [REG_SIZE-1:0]   wb_data_q;

    alu_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .pop_i   (fifo_pop),
        .wdata_i ({in_op, in_dest, in_result}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_op   = head[ENTRY_W-1 -: 4];
    assign head_dest = head[2*REG_SIZE +: 4];
    assign head_res  = head[2*REG_SIZE-1:0];

    assign in_ready  = !fifo_full;
    assign beat_done = wb_en_q && wb_ready;
    // The head entry stays in the FIFO until its last beat is accepted.
    assign fifo_pop  = (beat_done && ((state_q == S_LO_GPR) || (state_q == S_HI)))
                     || (state_q == S_DROP);

    assign wb_en     = wb_en_q;
    assign wb_target = wb_target_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wb_en_q     <= 1'b0;
            wb_target_q <= WB_TGT_GPR;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        case (op_class(head_op))
                            CLS_ONE: begin
                                state_q     <= S_LO_GPR;
                                wb_en_q     <= 1'b1;
                                wb_target_q <= WB_TGT_GPR;
                                wb_addr_q   <= head_dest;
                                wb_data_q   <= head_res[REG_SIZE-1:0];
                            end
                            CLS_TWO: begin
                                state_q     <= S_LO;
                                wb_en_q     <= 1'b1;
                                wb_target_q <= WB_TGT_LO;
                                wb_addr_q   <= '0;
                                wb_data_q   <= head_res[REG_SIZE-1:0];
                            end
                            default: state_q <= S_DROP;
                        endcase
                    end
                end
                S_LO: begin
                    if (wb_ready) begin
                        state_q     <= S_HI;
                        wb_target_q <= WB_TGT_HI;
                        wb_data_q   <= head_res[2*REG_SIZE-1:REG_SIZE];
                    end
                end
                S_LO_GPR, S_HI: begin
                    if (wb_ready) begin
                        state_q     <= S_IDLE;
                        wb_en_q     <= 1'b0;
                        wb_target_q <= WB_TGT_GPR;
                        wb_addr_q   <= '0;
                        wb_data_q   <= '0;
                    end
                end
                S_DROP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_WB_FLAGS_EN
    logic flag_z_q;
    logic flag_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (beat_done && (state_q == S_LO_GPR)) begin
            flag_z_q <= (head_res[REG_SIZE-1:0] == '0);
            flag_n_q <= head_res[REG_SIZE-1];
        end else if (beat_done && (state_q == S_HI)) begin
            flag_z_q <= (head_res == '0);
            flag_n_q <= head_res[2*REG_SIZE-1];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_writeback.sv
// ============================================================================
// tb_alu_result_writeback
// Vector table, directed corner sequences and a random scoreboard run.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        wb_ready = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [3:0]  in_dest = 4'd0;
    logic [63:0] in_result = 64'd0;
    logic        in_ready;
    logic        wb_en;
    logic [1:0]  wb_target;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef ALU_WB_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] res;
        logic [3:0]  dest;
        int          nb;
        logic [1:0]  t0;
        logic [3:0]  a0;
        logic [31:0] d0;
        logic [1:0]  t1;
        logic [31:0] d1;
        logic        z;
        logic        n;
    } vec_t;

    typedef struct packed {
        logic [1:0]  t;
        logic [3:0]  a;
        logic [31:0] d;
        logic        last;
        logic        z;
        logic        n;
    } beat_t;

    beat_t q[$];
    logic  exp_z = 1'b0;
    logic  exp_n = 1'b0;
    vec_t  vecs[11];

    always #5 clk = ~clk;

    alu_result_writeback #(.REG_SIZE(32), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_result (in_result),
        .in_dest   (in_dest),
        .wb_en     (wb_en),
        .wb_ready  (wb_ready),
        .wb_target (wb_target),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
`ifdef ALU_WB_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_n    (flag_n)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: an accepted result becomes 0, 1 or 2 expected bus beats.
    task automatic model_push(input logic [3:0] op, input logic [63:0] res, input logic [3:0] dest);
        if (op == 4'd8 || op == 4'd9) begin
            q.push_back('{t: 2'd1, a: 4'd0, d: res[31:0], last: 1'b0, z: 1'b0, n: 1'b0});
            q.push_back('{t: 2'd2, a: 4'd0, d: res[63:32], last: 1'b1,
                          z: (res == 64'd0), n: res[63]});
        end else if (op < 4'd12) begin
            q.push_back('{t: 2'd0, a: dest, d: res[31:0], last: 1'b1,
                          z: (res[31:0] == 32'd0), n: res[31]});
        end
    endtask

    task automatic rnd_cycle(input bit allow_push);
        logic acc_beat;
        logic acc_push;
        if (wb_en) begin
            if (q.size() == 0) chk("rnd_spurious_beat", 64'(wb_en), 64'd0);
            else chk("rnd_beat", {wb_target, wb_addr, wb_data}, {q[0].t, q[0].a, q[0].d});
        end
`ifdef ALU_WB_FLAGS_EN
        chk("rnd_flags", {flag_z, flag_n}, {exp_z, exp_n});
`endif
        wb_ready = allow_push ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_valid = allow_push && ($urandom_range(0, 1) == 1);
        in_op    = 4'($urandom_range(0, 15));
        in_dest  = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 7))
            0:       in_result = 64'd0;
            1:       in_result = {32'd0, 32'($urandom)};
            2:       in_result = {32'($urandom), 32'd0};
            default: in_result = {32'($urandom), 32'($urandom)};
        endcase
        acc_beat = wb_en && wb_ready;
        acc_push = in_valid && in_ready;
        tick();
        if (acc_beat && q.size() > 0) begin
            if (q[0].last) begin
                exp_z = q[0].z;
                exp_n = q[0].n;
            end
            void'(q.pop_front());
        end
        if (acc_push) model_push(in_op, in_result, in_dest);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [1:0]  bt[4];
        logic [3:0]  ba[4];
        logic [31:0] bd[4];
        int nb = 0;
        int first = -1;
        in_op = v.op; in_result = v.res; in_dest = v.dest;
        in_valid = 1'b1; wb_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (wb_en) begin
                if (nb < 4) begin
                    bt[nb] = wb_target; ba[nb] = wb_addr; bd[nb] = wb_data;
                end
                if (first < 0) first = c;
                nb++;
            end
            tick();
        end
        chk($sformatf("v%0d_beats", i), 64'(nb), 64'(v.nb));
        if (v.nb > 0) begin
            chk($sformatf("v%0d_latency", i), 64'(first), 64'd1);
            chk($sformatf("v%0d_beat0", i), {bt[0], ba[0], bd[0]}, {v.t0, v.a0, v.d0});
        end
        if (v.nb > 1) chk($sformatf("v%0d_beat1", i), {bt[1], ba[1], bd[1]}, {v.t1, 4'd0, v.d1});
        chk($sformatf("v%0d_idle", i), 64'(wb_en), 64'd0);
`ifdef ALU_WB_FLAGS_EN
        chk($sformatf("v%0d_flags", i), {flag_z, flag_n}, {v.z, v.n});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  bt[4];
        logic [3:0]  ba[4];
        logic [31:0] bd[4];
        int nb;

        vecs[0]  = '{4'b0010, 64'h0000_0000_0000_0007, 4'd5, 1, 2'd0, 4'd5, 32'h7, 2'd0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1000, 64'h0000_0001_8000_0000, 4'd2, 2, 2'd1, 4'd0, 32'h8000_0000, 2'd2, 32'h1, 1'b0, 1'b0};
        vecs[2]  = '{4'b1010, 64'h0000_0000_FFFF_FFFF, 4'd1, 1, 2'd0, 4'd1, 32'hFFFF_FFFF, 2'd0, 32'h0, 1'b0, 1'b1};
        vecs[3]  = '{4'b0011, 64'h0, 4'd4, 1, 2'd0, 4'd4, 32'h0, 2'd0, 32'h0, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 64'h8000_0000_0000_0001, 4'd7, 0, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 64'hFFFF_FFFF_0000_0005, 4'd3, 1, 2'd0, 4'd3, 32'h5, 2'd0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{4'b1001, 64'h0000_0003_1234_5678, 4'd9, 2, 2'd1, 4'd0, 32'h1234_5678, 2'd2, 32'h3, 1'b0, 1'b0};
        vecs[7]  = '{4'b1001, 64'h8000_0000_0000_0000, 4'd0, 2, 2'd1, 4'd0, 32'h0, 2'd2, 32'h8000_0000, 1'b0, 1'b1};
        vecs[8]  = '{4'b1000, 64'h0, 4'd6, 2, 2'd1, 4'd0, 32'h0, 2'd2, 32'h0, 1'b1, 1'b0};
        vecs[9]  = '{4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 0, 2'd0, 4'd0, 32'h0, 2'd0, 32'h0, 1'b1, 1'b0};
        vecs[10] = '{4'b1011, 64'h0000_0000_8000_0000, 4'd15, 1, 2'd0, 4'd15, 32'h8000_0000, 2'd0, 32'h0, 1'b0, 1'b1};

        // Reset state
        #1;
        chk("rst_outputs", {wb_en, wb_target, wb_addr, wb_data}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_WB_FLAGS_EN
        chk("rst_flags", {flag_z, flag_n}, 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Back-pressure: stall in S_LO while a third push waits for space.
        wb_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'b1000; in_dest = 4'd0; in_result = 64'h0000_00A1_0000_00A0;
        tick();
        chk("bp_ready_after_1", 64'(in_ready), 64'd1);
        in_op = 4'b0010; in_dest = 4'd6; in_result = 64'h0000_0000_0000_00B0;
        tick();
        chk("bp_ready_after_2", 64'(in_ready), 64'd0);
        in_op = 4'b0010; in_dest = 4'd7; in_result = 64'h0000_0000_0000_00C0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_stall%0d", c), {in_ready, wb_en, wb_target, wb_addr, wb_data},
                {1'b0, 1'b1, 2'd1, 4'd0, 32'hA0});
            tick();
        end
        wb_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            logic acc;
            acc = in_valid && in_ready;
            if (wb_en && wb_ready) begin
                if (nb < 4) begin
                    bt[nb] = wb_target; ba[nb] = wb_addr; bd[nb] = wb_data;
                end
                nb++;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("bp_beats", 64'(nb), 64'd4);
        chk("bp_b0", {bt[0], ba[0], bd[0]}, {2'd1, 4'd0, 32'hA0});
        chk("bp_b1", {bt[1], ba[1], bd[1]}, {2'd2, 4'd0, 32'hA1});
        chk("bp_b2", {bt[2], ba[2], bd[2]}, {2'd0, 4'd6, 32'hB0});
        chk("bp_b3", {bt[3], ba[3], bd[3]}, {2'd0, 4'd7, 32'hC0});

        // Reset while the HI beat is stalled and the FIFO is full.
        wb_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'b1000; in_result = 64'hAAAA_0001_BBBB_0002;
        tick();
        in_result = 64'hCCCC_0003_DDDD_0004;
        tick();
        in_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("rh_pre_hi", {in_ready, wb_en, wb_target, wb_data}, {1'b0, 1'b1, 2'd2, 32'hAAAA_0001});
        #2 rst_n = 1'b0;
        #1;
        chk("rh_outputs", {wb_en, wb_target, wb_addr, wb_data}, 64'd0);
        chk("rh_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_WB_FLAGS_EN
        chk("rh_flags", {flag_z, flag_n}, 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        wb_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            if (wb_en) nb++;
            tick();
        end
        chk("rh_no_beat_after", 64'(nb), 64'd0);

        // Random traffic against the beat-queue model, then drain.
        q.delete();
        exp_z = 1'b0;
        exp_n = 1'b0;
        for (int c = 0; c < 600; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 60 && (q.size() > 0 || wb_en); c++) rnd_cycle(1'b0);
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        chk("drain_idle", 64'(wb_en), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
